branch_resolver: RTL
====================

# branch_resolver

Sequencing and branch-resolution stage that pairs with `PC_change`. Consumes the current `pc` and the instruction word returned by the 1-cycle-latency instruction block RAM, and holds the architectural condition flags. Decides whether a branch is taken and drives `isBranch`/`label` back to `PC_change`. Also emits a one-cycle `pc_step` strobe per instruction and a link-register write for `call`.

## Interface
Parameters:
- `PC_W`, 12, program-counter width; must match `PC_change.pc`.
- `LBL_W`, 26, branch label width (`instr[25:0]`).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `pc`  input  PC_W  current PC from `PC_change`; also the BRAM address.
- `instr`  input  32  BRAM read data; valid one cycle after `pc` is stable.
- `flags_we`  input  1  ALU flag write enable.
- `zf_in`, `cf_in`, `sf_in`, `vf_in`  input  1 each  ALU zero, carry, sign and overflow results.
- `isBranch`  output  1  branch taken this EXEC cycle.
- `label`  output  LBL_W  branch target; valid when `isBranch`=1.
- `pc_step`  output  1  one-cycle strobe: PC may advance/branch.
- `ra`  output  PC_W  return address for `call`.
- `ra_we`  output  1  link-register write strobe.

## Operation
- FSM has three states: FETCH, DECODE, EXEC, cycling FETCH→DECODE→EXEC→FETCH unconditionally, one cycle each.
  - FETCH: BRAM access in flight; outputs idle.
  - DECODE: `ir <= instr`; `pc_q <= pc`.
  - EXEC: evaluate `ir` against the flag register; drive outputs for exactly this cycle.
- Opcode is `ir[31:26]`. Branch opcodes:
  - B = 0x20, always taken.
  - BZ = 0x21, taken if ZF; BNZ = 0x22, taken if !ZF.
  - BCY = 0x23, taken if CF; BNCY = 0x24, taken if !CF.
  - BS = 0x25, taken if SF; BNS = 0x26, taken if !SF.
  - BV = 0x27, taken if VF; BNV = 0x28, taken if !VF.
  - CALL = 0x29, always taken, plus a link write.
- Any other opcode is a non-branch: `isBranch`=0.
- In EXEC, `pc_step`=1. `isBranch`=taken. `label`=`ir[25:0]` whenever taken, otherwise 0.
- On CALL in EXEC: `ra_we`=1 and `ra`=`pc_q`+1, modulo 2^PC_W (0xFFF+1 → 0x000).
- The flag register {ZF,CF,SF,VF} loads from the `*_in` inputs at any edge where `flags_we`=1, in every state.

## Timing
- Reset values: state=FETCH; `ir`=0; `pc_q`=0; flags=0; `isBranch`=0; `label`=0; `pc_step`=0; `ra`=0; `ra_we`=0.
- All outputs are registered and are asserted only during EXEC, except `ra`, which holds its last value.
- Latency: the instruction at `pc` presented in FETCH resolves 2 cycles later, in EXEC. One instruction completes every 3 cycles.
- Flag hazard: a `flags_we` in the same cycle as EXEC does not affect that cycle's decision; the branch uses the pre-write flags. A write in FETCH or DECODE is visible in the following EXEC.
- `rst` asserted in any state returns to FETCH at the next edge. Any pending branch or `ra_we` is dropped, and the outputs deassert in that same edge's result.
- `rst` has priority over `flags_we`.

## Structure
- Shared package `kgp_risc_pkg`:
  - opcode constants (`OP_B`…`OP_CALL`);
  - FSM state encoding;
  - `PC_W`/`LBL_W` defaults.
- One natural sub-module, `branch_cond`: combinational opcode + flags → taken/is_call, instantiated once. The FSM, IR and flag registers live in `branch_resolver`.

## Test plan
- Reset: hold `rst`=1 for 3 cycles → all outputs 0 and flags 0. After release, the first `pc_step` arrives exactly 3 cycles later.
- Non-branch: `instr`=0x0400_0005 (opcode 0x01) → EXEC shows `pc_step`=1, `isBranch`=0, `label`=0, `ra_we`=0.
- Conditional:
  - `flags_we`=1 with `zf_in`=1 in FETCH, then `instr`=0x8400_0018 (BZ, label 24) → EXEC shows `isBranch`=1, `label`=24.
  - Same sequence with BNZ (0x8800_0018) → `isBranch`=0.
- Flag hazard: ZF=0 stored; `instr`=BZ; `flags_we`=1 with `zf_in`=1 during EXEC → `isBranch`=0. The next BZ is taken.
- CALL wrap: `pc`=0xFFF, `instr`=0xA400_0010 → EXEC shows `isBranch`=1, `label`=16, `ra_we`=1, `ra`=0x000.
- Reset mid-operation: assert `rst` in DECODE holding a taken B → no `isBranch`/`pc_step` pulse; FSM in FETCH next cycle.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the kgp_risc sequencing stage: opcodes, FSM encoding,
// flag bundle and default widths.
package kgp_risc_pkg;

  localparam int PC_W_DEF  = 12;
  localparam int LBL_W_DEF = 26;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_t;

  typedef struct packed {
    logic zf;
    logic cf;
    logic sf;
    logic vf;
  } flags_t;

  localparam logic [5:0] OP_B    = 6'h20;
  localparam logic [5:0] OP_BZ   = 6'h21;
  localparam logic [5:0] OP_BNZ  = 6'h22;
  localparam logic [5:0] OP_BCY  = 6'h23;
  localparam logic [5:0] OP_BNCY = 6'h24;
  localparam logic [5:0] OP_BS   = 6'h25;
  localparam logic [5:0] OP_BNS  = 6'h26;
  localparam logic [5:0] OP_BV   = 6'h27;
  localparam logic [5:0] OP_BNV  = 6'h28;
  localparam logic [5:0] OP_CALL = 6'h29;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition: opcode and flags in, taken / is_call out.
module branch_cond
  import kgp_risc_pkg::*;
(
  input  logic [5:0] opcode,
  input  flags_t     flags,
  output logic       taken,
  output logic       is_call
);

  // opcode/flag decode
  always_comb begin
    taken   = 1'b0;
    is_call = 1'b0;
    case (opcode)
      OP_B:    taken = 1'b1;
      OP_BZ:   taken = flags.zf;
      OP_BNZ:  taken = ~flags.zf;
      OP_BCY:  taken = flags.cf;
      OP_BNCY: taken = ~flags.cf;
      OP_BS:   taken = flags.sf;
      OP_BNS:  taken = ~flags.sf;
      OP_BV:   taken = flags.vf;
      OP_BNV:  taken = ~flags.vf;
      OP_CALL: begin
        taken   = 1'b1;
        is_call = 1'b1;
      end
      default: begin
        taken   = 1'b0;
        is_call = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// FETCH/DECODE/EXEC sequencer that resolves branches against the flag register
// and drives registered isBranch/label/pc_step/ra/ra_we for the EXEC cycle.
module branch_resolver
  import kgp_risc_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int LBL_W = LBL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             flags_we,
  input  logic             zf_in,
  input  logic             cf_in,
  input  logic             sf_in,
  input  logic             vf_in,
  output logic             isBranch,
  output logic [LBL_W-1:0] label,
  output logic             pc_step,
  output logic [PC_W-1:0]  ra,
  output logic             ra_we
);

  state_t            state_r, state_s;
  logic [31:0]       ir_r, ir_s;
  logic [PC_W-1:0]   pc_q_r, pc_q_s;
  flags_t            flags_r, flags_s;

  logic              taken_s, is_call_s;
  logic              is_branch_s, pc_step_s, ra_we_s;
  logic [LBL_W-1:0]  label_s;
  logic [PC_W-1:0]   ra_s;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state: unconditional three-phase rotation
  always_comb begin
    state_s = ST_FETCH;
    case (state_r)
      ST_FETCH:  state_s = ST_DECODE;
      ST_DECODE: state_s = ST_EXEC;
      ST_EXEC:   state_s = ST_FETCH;
      default:   state_s = ST_FETCH;
    endcase
  end

  // Values ir/pc_q/flags will hold during the coming cycle; outputs are
  // registered, so the EXEC decision is formed from these at the DECODE edge.
  always_comb begin
    ir_s   = ir_r;
    pc_q_s = pc_q_r;
    if (state_r == ST_DECODE) begin
      ir_s   = instr;
      pc_q_s = pc;
    end else begin
      ir_s   = ir_r;
      pc_q_s = pc_q_r;
    end
    if (flags_we) begin
      flags_s = '{zf: zf_in, cf: cf_in, sf: sf_in, vf: vf_in};
    end else begin
      flags_s = flags_r;
    end
  end

  // IR, captured PC and architectural flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r    <= 32'd0;
      pc_q_r  <= {PC_W{1'b0}};
      flags_r <= '{zf: 1'b0, cf: 1'b0, sf: 1'b0, vf: 1'b0};
    end else begin
      ir_r    <= ir_s;
      pc_q_r  <= pc_q_s;
      flags_r <= flags_s;
    end
  end

  branch_cond u_branch_cond (
    .opcode  (ir_s[31:26]),
    .flags   (flags_s),
    .taken   (taken_s),
    .is_call (is_call_s)
  );

  // output decode: non-idle only for the cycle that will be EXEC
  always_comb begin
    is_branch_s = 1'b0;
    label_s     = {LBL_W{1'b0}};
    pc_step_s   = 1'b0;
    ra_we_s     = 1'b0;
    ra_s        = ra;
    if (state_r == ST_DECODE) begin
      pc_step_s   = 1'b1;
      is_branch_s = taken_s;
      label_s     = taken_s ? ir_s[LBL_W-1:0] : {LBL_W{1'b0}};
      ra_we_s     = is_call_s;
      ra_s        = is_call_s ? (pc_q_s + {{(PC_W-1){1'b0}}, 1'b1}) : ra;
    end else begin
      pc_step_s   = 1'b0;
      is_branch_s = 1'b0;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      isBranch <= 1'b0;
      label    <= {LBL_W{1'b0}};
      pc_step  <= 1'b0;
      ra       <= {PC_W{1'b0}};
      ra_we    <= 1'b0;
    end else begin
      isBranch <= is_branch_s;
      label    <= label_s;
      pc_step  <= pc_step_s;
      ra       <= ra_s;
      ra_we    <= ra_we_s;
    end
  end

endmodule
